// File: rtl/shift_sweep_ctrl_pkg.sv
// Shared types and constants for the shift sweep controller.
// Build option: SHIFT_SWEEP_CHECK_EN enables the popcount checker.
package shift_sweep_pkg;

    localparam int DATA_W = 4;
    localparam int NSTEPS = 4;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 4;
    localparam int OUT_W  = DATA_W * NSTEPS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_OUT
    } state_e;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]}
             + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/shift_sweep_ctrl_if.sv
// Upstream word and downstream result handshakes of the sweep controller.
// The controller uses the slave view; its environment uses master.
interface shift_sweep_ctrl_if;
    import shift_sweep_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/shift_sweep_ctrl.sv
// Sweeps an external barrel shifter over all four select values and packs the results.
// Define SHIFT_SWEEP_CHECK_EN to build the sticky popcount-mismatch flag on err.
module shift_sweep_ctrl
    import shift_sweep_pkg::*;
#(
    parameter int STEP_HOLD = 1
) (
    input  logic              clk,
    input  logic              rst,
    shift_sweep_ctrl_if.slave bus,
    output logic [DATA_W-1:0] sh_x,
    output logic [SEL_W-1:0]  sh_select,
    input  logic [DATA_W-1:0] sh_y,
    output logic              busy,
    output logic              err
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(STEP_HOLD - 1);
    localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NSTEPS - 1);

    state_e            state;
    state_e            state_n;
    logic [CNT_W-1:0]  hold_cnt;
    logic [OUT_W-1:0]  out_q;
    logic              accept;
    logic              sample;

    assign accept = (state == S_IDLE) && bus.in_valid;
    assign sample = (state == S_SWEEP) && (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (bus.in_valid) state_n = S_SWEEP;
            end
            S_SWEEP: begin
                if (sample && (sh_select == SEL_LAST)) state_n = S_OUT;
            end
            S_OUT: begin
                if (bus.out_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b1;
        case (state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                busy         = 1'b0;
            end
            S_OUT:   bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    // sh_x is only loaded on accept, so it stays put for the whole sweep and OUT
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_x      <= '0;
            sh_select <= '0;
            hold_cnt  <= '0;
            out_q     <= '0;
        end else if (accept) begin
            sh_x      <= bus.in_data;
            sh_select <= '0;
            hold_cnt  <= '0;
            out_q     <= '0;
        end else if (state == S_SWEEP) begin
            if (sample) begin
                out_q[{sh_select, 2'b00} +: DATA_W] <= sh_y;
                if (sh_select != SEL_LAST) begin
                    sh_select <= sh_select + 1'b1;
                    hold_cnt  <= '0;
                end
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    assign bus.out_data = out_q;

`ifdef SHIFT_SWEEP_CHECK_EN
    logic err_q;

    // A rotate preserves popcount; any drift means a faulty shifter
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (sample && (popcount4(sh_y) != popcount4(sh_x))) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
